// File: rtl/vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vga_plot_arbiter
// Description : Round-robin arbiter that shares the VGA adapter write port
//               among four pixel producers (0 clear engine, 1 player trails,
//               2 timer bar, 3 winner numbers). Each producer offers one
//               pixel at a time over a req/ack handshake. The winning pixel
//               is registered onto x/y/colour with a one-cycle plot strobe;
//               off-screen pixels are acknowledged but not plotted and are
//               counted in a saturating drop counter.
//
// Ports       :
//   CLOCK_50    in   1   system clock, rising edge
//   resetn      in   1   asynchronous active-low reset
//   lock        in   1   restricts eligibility to requester 0 (clear engine)
//   req         in   4   per-requester pixel request
//   req_x       in  32   packed 8-bit x, requester i at [8i+7:8i]
//   req_y       in  28   packed 7-bit y, requester i at [7i+6:7i]
//   req_colour  in  12   packed 3-bit colour, requester i at [3i+2:3i]
//   ack         out  4   one-hot, one-cycle acknowledge of consumed pixel
//   x           out  8   pixel x to VGA adapter
//   y           out  7   pixel y to VGA adapter
//   colour      out  3   pixel colour to VGA adapter
//   plot        out  1   one-cycle write strobe to VGA adapter
//   drop_count  out  8   saturating count of discarded off-screen pixels
//
// Revision    : 1.0  initial release
// ============================================================================
module vga_plot_arbiter #(
    parameter int unsigned X_MAX = 159,
    parameter int unsigned Y_MAX = 119
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        lock,
    input  logic [3:0]  req,
    input  logic [31:0] req_x,
    input  logic [27:0] req_y,
    input  logic [11:0] req_colour,
    output logic [3:0]  ack,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic [7:0]  drop_count
);

    localparam logic [7:0] c_X_MAX     = X_MAX[7:0];
    localparam logic [6:0] c_Y_MAX     = Y_MAX[6:0];
    localparam logic [7:0] c_DROP_SAT  = 8'hFF;
    localparam logic [3:0] c_LOCK_MASK = 4'b0001;

    // Round-robin pointer: the requester searched first on the next edge.
    logic [1:0] r_ptr;

    // Unpacked per-requester payloads.
    logic [7:0] w_px [4];
    logic [6:0] w_py [4];
    logic [2:0] w_pc [4];

    logic [3:0] w_elig;
    logic [1:0] w_cand;
    logic [1:0] w_win;
    logic       w_found;
    logic [3:0] w_win_oh;
    logic       w_on_screen;

    for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
        assign w_px[gi] = req_x[8*gi +: 8];
        assign w_py[gi] = req_y[7*gi +: 7];
        assign w_pc[gi] = req_colour[3*gi +: 3];
    end

    // A requester acked this cycle still shows req high (it has not yet seen
    // the ack), so it must be masked or its pixel would be consumed twice.
    always_comb begin
        w_elig = req & ~ack;
        if (lock) begin
            w_elig = w_elig & c_LOCK_MASK;
        end
    end

    // Search from r_ptr upward (mod 4). Iterating from the farthest offset
    // down lets the nearest eligible requester overwrite the result last.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_cand  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_cand = r_ptr + 2'(k);
            if (w_elig[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_win_oh    = 4'b0001 << w_win;
    assign w_on_screen = (w_px[w_win] <= c_X_MAX) && (w_py[w_win] <= c_Y_MAX);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_ptr      <= 2'd0;
            ack        <= 4'b0000;
            plot       <= 1'b0;
            x          <= 8'd0;
            y          <= 7'd0;
            colour     <= 3'd0;
            drop_count <= 8'd0;
        end else if (w_found) begin
            r_ptr  <= w_win + 2'd1;
            ack    <= w_win_oh;
            x      <= w_px[w_win];
            y      <= w_py[w_win];
            colour <= w_pc[w_win];
            plot   <= w_on_screen;
            // Off-screen pixels are still acknowledged so the producer
            // advances; they are only counted, never written.
            if (!w_on_screen && (drop_count != c_DROP_SAT)) begin
                drop_count <= drop_count + 8'd1;
            end
        end else begin
            // Payload registers hold their last value when idle.
            ack  <= 4'b0000;
            plot <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_plot_arbiter
// Description : Directed self-checking bench for vga_plot_arbiter. Inputs
//               are driven and outputs observed on the falling clock edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_plot_arbiter;

    logic        CLOCK_50;
    logic        resetn;
    logic        lock;
    logic [3:0]  req;
    logic [31:0] req_x;
    logic [27:0] req_y;
    logic [11:0] req_colour;
    logic [3:0]  ack;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic [7:0]  drop_count;

    int n_cmp;
    int n_err;

    vga_plot_arbiter #(
        .X_MAX (159),
        .Y_MAX (119)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .resetn     (resetn),
        .lock       (lock),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .ack        (ack),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .drop_count (drop_count)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Observed bundle: {ack, plot, x, y, colour} = 4+1+8+7+3 = 23 bits.
    logic [22:0] obs;
    assign obs = {ack, plot, x, y, colour};

    task automatic set_pix(input int i, input logic [7:0] px, input logic [6:0] py,
                           input logic [2:0] pc);
        req_x[8*i +: 8]      = px;
        req_y[7*i +: 7]      = py;
        req_colour[3*i +: 3] = pc;
    endtask

    // Requester i payload: x=10+i, y=20+i, colour=i+1.
    task automatic load_distinct();
        for (int i = 0; i < 4; i++) begin
            set_pix(i, 8'(10 + i), 7'(20 + i), 3'(i + 1));
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        lock   = 1'b0;
        req    = 4'b0000;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [22:0] exp;
        do_reset();
        load_distinct();
        req = 4'b1111;
        repeat (3) @(negedge CLOCK_50);
        // Assert reset mid-cycle, well away from any edge.
        @(posedge CLOCK_50);
        #5 resetn = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 23'd0 || drop_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_async: obs=%h drop=%0d required obs=0 drop=0", obs, drop_count);
        end
        @(negedge CLOCK_50);
        resetn = 1'b1;
        @(negedge CLOCK_50);
        exp = {4'b0001, 1'b1, 8'd10, 7'd20, 3'd1};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_first_grant: obs=%h required %h", obs, exp);
        end
        req = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [22:0] exp;
        int          w;
        do_reset();
        load_distinct();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLOCK_50);
            w   = k % 4;
            exp = {4'(1 << w), 1'b1, 8'(10 + w), 7'(20 + w), 3'(w + 1)};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL round_robin[%0d]: obs=%h required %h", k, obs, exp);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_single();
        logic [22:0] exp;
        do_reset();
        load_distinct();
        set_pix(2, 8'd10, 7'd20, 3'b111);
        req = 4'b0100;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLOCK_50);
            if (k % 2 == 1) exp = {4'b0100, 1'b1, 8'd10, 7'd20, 3'd7};
            else            exp = {4'b0000, 1'b0, 8'd10, 7'd20, 3'd7};
            n_cmp++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL single[%0d]: obs=%h required %h", k, obs, exp);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_drop();
        int plots;
        do_reset();
        load_distinct();
        set_pix(1, 8'd160, 7'd5, 3'd2);
        req = 4'b0010;
        @(negedge CLOCK_50);
        n_cmp++;
        if (ack !== 4'b0010 || plot !== 1'b0 || drop_count !== 8'd1) begin
            n_err++;
            $display("FAIL drop_x: ack=%b plot=%b drop=%0d required ack=0010 plot=0 drop=1",
                     ack, plot, drop_count);
        end
        set_pix(1, 8'd5, 7'd120, 3'd2);
        repeat (2) @(negedge CLOCK_50);
        n_cmp++;
        if (ack !== 4'b0010 || plot !== 1'b0 || drop_count !== 8'd2 || y !== 7'd120) begin
            n_err++;
            $display("FAIL drop_y: ack=%b plot=%b drop=%0d y=%0d required ack=0010 plot=0 drop=2 y=120",
                     ack, plot, drop_count, y);
        end
        // Boundary pixel (159,119) is on-screen.
        set_pix(1, 8'd159, 7'd119, 3'd2);
        repeat (2) @(negedge CLOCK_50);
        n_cmp++;
        if (ack !== 4'b0010 || plot !== 1'b1 || drop_count !== 8'd2) begin
            n_err++;
            $display("FAIL drop_edge: ack=%b plot=%b drop=%0d required ack=0010 plot=1 drop=2",
                     ack, plot, drop_count);
        end
        // 300 more off-screen pixels, one grant every other cycle.
        set_pix(1, 8'd200, 7'd5, 3'd2);
        plots = 0;
        repeat (600) begin
            @(negedge CLOCK_50);
            if (plot) plots++;
        end
        req = 4'b0000;
        n_cmp++;
        if (drop_count !== 8'd255 || plots != 0) begin
            n_err++;
            $display("FAIL drop_saturate: drop=%0d plots=%0d required drop=255 plots=0",
                     drop_count, plots);
        end
    endtask

    task automatic test_lock();
        logic [3:0] exp_ack [3];
        do_reset();
        load_distinct();
        lock = 1'b1;
        req  = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLOCK_50);
            n_cmp++;
            if (ack !== 4'b0000 || plot !== 1'b0) begin
                n_err++;
                $display("FAIL lock_block[%0d]: ack=%b plot=%b required ack=0000 plot=0", k, ack, plot);
            end
        end
        req = 4'b1111;
        exp_ack[0] = 4'b0001;
        exp_ack[1] = 4'b0000;
        exp_ack[2] = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLOCK_50);
            n_cmp++;
            if (ack !== exp_ack[k] || plot !== exp_ack[k][0]) begin
                n_err++;
                $display("FAIL lock_only0[%0d]: ack=%b plot=%b required ack=%b", k, ack, plot, exp_ack[k]);
            end
        end
        // Requester 0 is done; unlock. Pointer now sits at 1.
        req  = 4'b1110;
        lock = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLOCK_50);
            n_cmp++;
            if (ack !== 4'(1 << k) || plot !== 1'b1 || x !== 8'(10 + k)) begin
                n_err++;
                $display("FAIL lock_resume[%0d]: ack=%b plot=%b x=%0d required ack=%b plot=1 x=%0d",
                         k, ack, plot, x, 4'(1 << k), 10 + k);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_payload_hold();
        logic [22:0] exp;
        int          old_plots;
        do_reset();
        load_distinct();
        set_pix(3, 8'd30, 7'd40, 3'd2);
        req       = 4'b1000;
        old_plots = 0;
        @(negedge CLOCK_50);
        if (plot && x == 8'd30) old_plots++;
        exp = {4'b1000, 1'b1, 8'd30, 7'd40, 3'd2};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL hold_first: obs=%h required %h", obs, exp);
        end
        set_pix(3, 8'd31, 7'd41, 3'd5);
        @(negedge CLOCK_50);
        if (plot && x == 8'd30) old_plots++;
        @(negedge CLOCK_50);
        if (plot && x == 8'd30) old_plots++;
        exp = {4'b1000, 1'b1, 8'd31, 7'd41, 3'd5};
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL hold_next: obs=%h required %h", obs, exp);
        end
        req = 4'b0000;
        n_cmp++;
        if (old_plots != 1) begin
            n_err++;
            $display("FAIL hold_once: old payload plotted %0d times, required 1", old_plots);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        resetn     = 1'b0;
        lock       = 1'b0;
        req        = 4'b0000;
        req_x      = 32'd0;
        req_y      = 28'd0;
        req_colour = 12'd0;
        test_reset();
        test_round_robin();
        test_single();
        test_drop();
        test_lock();
        test_payload_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
